mem_test_master: RTL and testbench

MEM_TEST_MASTER -- requirements
Module: mem_test_master

---
 rtl/mem_test_pkg.sv | 24 ++
 rtl/mem_test_master_if.sv | 28 ++
 rtl/mem_test_master.sv | 150 +++++++++++++++
 tb/tb_mem_test_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared types, default widths and the test-pattern generator for the
// Avalon-MM memory test master.
package mem_test_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int PAT_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Word i carries seed XOR zero-extended i; callers truncate to their width.
  function automatic logic [PAT_W-1:0] word_pattern(input logic [PAT_W-1:0] seed,
                                                     input logic [PAT_W-1:0] idx);
    return seed ^ idx;
  endfunction

endpackage

// File: rtl/mem_test_master_if.sv
// Avalon-MM word-addressed bus between the test master and a memory slave.
interface mem_test_master_if
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest, readdatavalid
  );

endinterface

// File: rtl/mem_test_master.sv
// Memory test master: writes a seeded pattern over a word range, reads it back
// one word at a time and reports mismatch count and first failing address.
module mem_test_master
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mem_test_master_if.master avm
);

  localparam logic [ADDR_W:0]  IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [DATA_W-1:0] pat_of(input logic [DATA_W-1:0] s,
                                               input logic [ADDR_W:0]   i);
    return DATA_W'(word_pattern(PAT_W'(s), PAT_W'(i)));
  endfunction

  state_e            state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] seed_r;

  logic [ADDR_W:0]   idx_inc;
  logic              last_word;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] cur_pat;
  logic              rd_take;
  logic              mismatch;

  assign idx_inc   = idx + IDX_ONE;
  assign last_word = (idx_inc == count_r);
  assign cur_addr  = base_r + idx[ADDR_W-1:0];
  assign nxt_addr  = base_r + idx_inc[ADDR_W-1:0];
  assign cur_pat   = pat_of(seed_r, idx);

  // Data is taken in RD_WAIT, or in RD_REQ when it arrives with the acceptance.
  assign rd_take  = avm.readdatavalid &&
                    ((state == ST_RD_WAIT) || (state == ST_RD_REQ && !avm.waitrequest));
  assign mismatch = rd_take && (avm.readdata != cur_pat);

  assign avm.byteenable = '1;

  // Run parameters are held for the whole run; they need no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      base_r  <= base_addr;
      count_r <= word_count;
      seed_r  <= seed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      avm.read       <= 1'b0;
      avm.write      <= 1'b0;
      avm.address    <= '0;
      avm.writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            idx            <= '0;
            if (word_count == '0) begin
              state <= ST_FIN;
            end else begin
              state         <= ST_WR;
              avm.write     <= 1'b1;
              avm.address   <= base_addr;
              avm.writedata <= pat_of(seed, '0);
            end
          end
        end
        ST_WR: begin
          if (!avm.waitrequest) begin
            if (last_word) begin
              idx         <= '0;
              avm.write   <= 1'b0;
              avm.read    <= 1'b1;
              avm.address <= base_r;
              state       <= ST_RD_REQ;
            end else begin
              idx           <= idx_inc;
              avm.address   <= nxt_addr;
              avm.writedata <= pat_of(seed_r, idx_inc);
            end
          end
        end
        ST_RD_REQ, ST_RD_WAIT: begin
          if (rd_take) begin
            if (last_word) begin
              avm.read <= 1'b0;
              state    <= ST_FIN;
            end else begin
              idx         <= idx_inc;
              avm.read    <= 1'b1;
              avm.address <= nxt_addr;
              state       <= ST_RD_REQ;
            end
          end else if (state == ST_RD_REQ && !avm.waitrequest) begin
            avm.read <= 1'b0;
            state    <= ST_RD_WAIT;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + CNT_ONE;
        if (err_count == '0)
          first_err_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: behavioural Avalon-MM RAM slave with programmable
// waitrequest and read-fault injection, checked against a run-level model.
module tb_mem_test_master;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          start      = 1'b0;
  logic [AW-1:0] base_addr  = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] seed       = '0;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  int n_checks = 0;
  int n_errs   = 0;

  mem_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm ();

  mem_test_master #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (avm)
  );

  always #5 clk = ~clk;

  // Behavioural slave: 8192x32 RAM, read latency 1, random waitrequest.
  logic [DW-1:0] ram [0:8191];
  int            wait_pct = 0;
  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_a  = '0;
  logic [AW-1:0] fault_b  = '0;
  int            wr_total = 0, rd_total = 0, stab_err = 0, both_err = 0;
  logic [AW-1:0] wr_log [0:1023];
  logic          prev_pend = 1'b0;
  logic [AW+DW+1:0] prev_cmd = '0;

  always @(negedge clk)
    avm.waitrequest <= (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);

  always @(posedge clk) begin
    avm.readdatavalid <= 1'b0;
    if (avm.read && !avm.waitrequest) begin
      avm.readdatavalid <= 1'b1;
      avm.readdata <= ram[avm.address] ^
                      {{(DW-1){1'b0}}, fault_en && (avm.address == fault_a || avm.address == fault_b)};
      rd_total <= rd_total + 1;
    end
    if (avm.write && !avm.waitrequest) begin
      ram[avm.address]       <= avm.writedata;
      wr_log[wr_total % 1024] <= avm.address;
      wr_total               <= wr_total + 1;
    end
    if (avm.read && avm.write) both_err <= both_err + 1;
    if (prev_pend && ({avm.read, avm.write, avm.address, avm.writedata} != prev_cmd))
      stab_err <= stab_err + 1;
    prev_pend <= (avm.read || avm.write) && avm.waitrequest && !reset;
    prev_cmd  <= {avm.read, avm.write, avm.address, avm.writedata};
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: errors are the words of the run whose address is faulted.
  function automatic void model(input int b, input int n, input bit fen,
                                input int fa, input int fb,
                                output int exp_err, output int exp_first);
    exp_err = 0; exp_first = 0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % 8192;
      if (fen && (a == fa || a == fb)) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
  endfunction

  task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s,
                     output int cyc, output bit got);
    @(negedge clk);
    base_addr = b; word_count = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    got = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_errs++; $display("FAIL reset_pass: got %b want 0", pass); end
    n_checks++; if (err_count !== '0) begin n_errs++; $display("FAIL reset_err: got %h want 0", err_count); end
    n_checks++; if (first_err_addr !== '0) begin n_errs++; $display("FAIL reset_first: got %h want 0", first_err_addr); end
    n_checks++; if ({avm.read, avm.write} !== 2'b00) begin n_errs++; $display("FAIL reset_rw: got %b want 00", {avm.read, avm.write}); end
    n_checks++; if (avm.address !== '0) begin n_errs++; $display("FAIL reset_addr: got %h want 0", avm.address); end
    n_checks++; if (avm.writedata !== '0) begin n_errs++; $display("FAIL reset_wdata: got %h want 0", avm.writedata); end
    n_checks++; if (avm.byteenable !== 4'hF) begin n_errs++; $display("FAIL byteenable: got %h want f", avm.byteenable); end
    reset = 1'b0;
  endtask

  task automatic test_clean();
    int cyc, w0, r0; bit got;
    wait_pct = 0; fault_en = 1'b0; w0 = wr_total; r0 = rd_total;
    run(13'h0100, 14'd16, 32'hA5A5A5A5, cyc, got);
    n_checks++; if (!got) begin n_errs++; $display("FAIL clean_done: timeout after %0d cycles", cyc); end
    n_checks++; if (cyc != 3*16+2) begin n_errs++; $display("FAIL clean_latency: got %0d want %0d", cyc, 3*16+2); end
    n_checks++; if (pass !== 1'b1) begin n_errs++; $display("FAIL clean_pass: got %b want 1", pass); end
    n_checks++; if (err_count !== '0) begin n_errs++; $display("FAIL clean_err: got %0d want 0", err_count); end
    n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL clean_busy: got %b want 0", busy); end
    n_checks++; if (wr_total - w0 != 16) begin n_errs++; $display("FAIL clean_writes: got %0d want 16", wr_total - w0); end
    n_checks++; if (rd_total - r0 != 16) begin n_errs++; $display("FAIL clean_reads: got %0d want 16", rd_total - r0); end
    n_checks++; if (ram[13'h0105] !== 32'hA5A5A5A0) begin n_errs++; $display("FAIL clean_ram105: got %h want a5a5a5a0", ram[13'h0105]); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_errs++; $display("FAIL clean_done_pulse: got %b want 0", done); end
    n_checks++; if (pass !== 1'b1) begin n_errs++; $display("FAIL clean_pass_held: got %b want 1", pass); end
  endtask

  task automatic test_faults();
    int cyc; bit got;
    fault_en = 1'b1; fault_a = 13'h0103; fault_b = 13'h0107;
    run(13'h0100, 14'd16, 32'hA5A5A5A5, cyc, got);
    n_checks++; if (!got) begin n_errs++; $display("FAIL fault_done: timeout after %0d cycles", cyc); end
    n_checks++; if (pass !== 1'b0) begin n_errs++; $display("FAIL fault_pass: got %b want 0", pass); end
    n_checks++; if (err_count !== 16'd2) begin n_errs++; $display("FAIL fault_err: got %0d want 2", err_count); end
    n_checks++; if (first_err_addr !== 13'h0103) begin n_errs++; $display("FAIL fault_first: got %h want 0103", first_err_addr); end
    fault_en = 1'b0;
  endtask

  task automatic test_wrap_backpressure();
    int cyc, w0, s0; bit got; logic [DW-1:0] s;
    s = $urandom; wait_pct = 50; w0 = wr_total; s0 = stab_err;
    run(13'h1FFE, 14'd4, s, cyc, got);
    n_checks++; if (!got) begin n_errs++; $display("FAIL wrap_done: timeout after %0d cycles", cyc); end
    n_checks++; if (wr_total - w0 != 4) begin n_errs++; $display("FAIL wrap_writes: got %0d want 4", wr_total - w0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (int'(wr_log[(w0 + i) % 1024]) != (8190 + i) % 8192) begin
        n_errs++; $display("FAIL wrap_addr%0d: got %h want %h", i, wr_log[(w0 + i) % 1024], (8190 + i) % 8192);
      end
    end
    n_checks++; if (stab_err - s0 != 0) begin n_errs++; $display("FAIL wrap_stable: got %0d changes want 0", stab_err - s0); end
    n_checks++; if (pass !== 1'b1) begin n_errs++; $display("FAIL wrap_pass: got %b want 1", pass); end
    n_checks++; if (ram[13'h0001] !== (s ^ 32'd3)) begin n_errs++; $display("FAIL wrap_ram1: got %h want %h", ram[13'h0001], s ^ 32'd3); end
    wait_pct = 0;
  endtask

  task automatic test_edge();
    int cyc, w0, r0; bit got; logic [DW-1:0] s1;
    w0 = wr_total; r0 = rd_total;
    run(13'h0055, 14'd0, 32'h12345678, cyc, got);
    n_checks++; if (!got || cyc != 2) begin n_errs++; $display("FAIL zero_latency: got %0d (done=%b) want 2", cyc, got); end
    n_checks++; if (pass !== 1'b1 || err_count !== '0) begin n_errs++; $display("FAIL zero_result: got pass=%b err=%0d want 1/0", pass, err_count); end
    n_checks++; if (wr_total != w0 || rd_total != r0) begin n_errs++; $display("FAIL zero_bus: got %0d/%0d accesses want 0", wr_total - w0, rd_total - r0); end
    // Start while busy (cycle 5) and while finishing (cycle 25) must be ignored.
    s1 = $urandom; w0 = wr_total;
    @(negedge clk);
    base_addr = 13'h0200; word_count = 14'd8; seed = s1; start = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 5) || (cyc == 25);
      if (cyc == 5) begin
        base_addr = 13'h0300; word_count = 14'd3; seed = ~s1;
        n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL busy_mid: got %b want 1", busy); end
      end
      got = done;
    end
    start = 1'b0;
    n_checks++; if (!got || cyc != 26) begin n_errs++; $display("FAIL busy_ignore_latency: got %0d want 26", cyc); end
    n_checks++; if (pass !== 1'b1) begin n_errs++; $display("FAIL busy_ignore_pass: got %b want 1", pass); end
    n_checks++; if (ram[13'h0207] !== (s1 ^ 32'd7)) begin n_errs++; $display("FAIL busy_ignore_ram: got %h want %h", ram[13'h0207], s1 ^ 32'd7); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || wr_total - w0 != 8) begin n_errs++; $display("FAIL fin_start_ignored: got busy=%b writes=%0d want 0/8", busy, wr_total - w0); end
  endtask

  task automatic test_reset_midrun();
    int cyc, dn; bit got; logic [DW-1:0] s;
    s = $urandom;
    @(negedge clk);
    base_addr = 13'h0400; word_count = 14'd10; seed = s; start = 1'b1;
    cyc = 0;
    while (cyc < 22) begin @(negedge clk); cyc++; start = 1'b0; end
    n_checks++; if ({busy, avm.read, avm.readdatavalid} !== 3'b101) begin n_errs++; $display("FAIL midrun_rdwait: got busy/read/rdv=%b want 101", {busy, avm.read, avm.readdatavalid}); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if ({busy, avm.read, avm.write, done} !== 4'b0000) begin n_errs++; $display("FAIL midrun_abort: got busy/read/write/done=%b want 0000", {busy, avm.read, avm.write, done}); end
    n_checks++; if (err_count !== '0) begin n_errs++; $display("FAIL midrun_err: got %0d want 0", err_count); end
    dn = 0;
    repeat (6) begin @(negedge clk); if (done) dn++; end
    n_checks++; if (dn != 0 || busy !== 1'b0) begin n_errs++; $display("FAIL midrun_no_done: got %0d pulses busy=%b want 0/0", dn, busy); end
    s = $urandom;
    run(13'h0400, 14'd10, s, cyc, got);
    n_checks++; if (!got || cyc != 32) begin n_errs++; $display("FAIL midrun_rerun_latency: got %0d want 32", cyc); end
    n_checks++; if (pass !== 1'b1 || ram[13'h0409] !== (s ^ 32'd9)) begin n_errs++; $display("FAIL midrun_rerun: got pass=%b ram=%h want 1/%h", pass, ram[13'h0409], s ^ 32'd9); end
  endtask

  task automatic test_random();
    int cyc, w0, r0, s0, b, n, fa, fb, exp_err, exp_first, bad; bit got; logic [DW-1:0] s;
    for (int it = 0; it < 9; it++) begin
      b = int'($urandom_range(8191)); n = int'($urandom_range(24, 1)); s = $urandom;
      wait_pct = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 25 : 60);
      fault_en = 1'($urandom_range(1));
      fa = (b + int'($urandom_range(n - 1))) % 8192;
      fb = $urandom_range(1) ? (b + int'($urandom_range(n - 1))) % 8192 : int'($urandom_range(8191));
      fault_a = AW'(fa); fault_b = AW'(fb);
      model(b, n, fault_en, fa, fb, exp_err, exp_first);
      w0 = wr_total; r0 = rd_total; s0 = stab_err;
      run(AW'(b), (AW+1)'(n), s, cyc, got);
      n_checks++; if (!got) begin n_errs++; $display("FAIL rnd%0d_done: timeout after %0d cycles", it, cyc); end
      n_checks++; if (pass !== (exp_err == 0)) begin n_errs++; $display("FAIL rnd%0d_pass: got %b want %b", it, pass, exp_err == 0); end
      n_checks++; if (int'(err_count) != exp_err) begin n_errs++; $display("FAIL rnd%0d_err: got %0d want %0d", it, err_count, exp_err); end
      n_checks++; if (int'(first_err_addr) != exp_first) begin n_errs++; $display("FAIL rnd%0d_first: got %h want %h", it, first_err_addr, exp_first); end
      n_checks++; if (wr_total - w0 != n || rd_total - r0 != n) begin n_errs++; $display("FAIL rnd%0d_bus: got %0d/%0d want %0d", it, wr_total - w0, rd_total - r0, n); end
      n_checks++; if (stab_err - s0 != 0 || both_err != 0) begin n_errs++; $display("FAIL rnd%0d_cmd: got %0d changes %0d overlaps want 0/0", it, stab_err - s0, both_err); end
      bad = 0;
      for (int i = 0; i < n; i++)
        if (ram[(b + i) % 8192] !== (s ^ DW'(i))) bad++;
      n_checks++; if (bad != 0) begin n_errs++; $display("FAIL rnd%0d_ram: got %0d bad words want 0", it, bad); end
      if (wait_pct == 0) begin
        n_checks++; if (cyc != 3*n + 2) begin n_errs++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, cyc, 3*n + 2); end
      end
    end
    wait_pct = 0; fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_faults();
    test_wrap_backpressure();
    test_edge();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
